// File: rtl/act_skew_feeder.sv
// Skews activation vectors onto the systolic array west edge (lane r lags lane 0 by r
// advances), drives the array-wide compute enable and drains zeros after the last vector.
module act_skew_feeder #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   in_data,
  input  logic                     in_last,
  output logic [ROWS*DATA_W-1:0]   west_out,
  output logic                     compute,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam int CNT_W = $clog2(ROWS + COLS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROWS + COLS - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             draining;
  logic             xfer;
  logic             adv;

  assign draining = (state == DRAIN);
  assign xfer     = in_valid & in_ready & ~draining;
  assign adv      = xfer | draining;

  // One register chain per lane; the chain length r+1 is what produces the diagonal skew.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_W-1:0] chain [r+1];

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int k = 0; k <= r; k++) chain[k] <= '0;
      end else if (adv) begin
        chain[0] <= draining ? '0 : in_data[r*DATA_W +: DATA_W];
        for (int k = 1; k <= r; k++) chain[k] <= chain[k-1];
      end
    end

    assign west_out[r*DATA_W +: DATA_W] = chain[r];
  end

  // in_ready and busy are registered alongside the state so they reflect the state just entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      compute  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      compute <= adv;
      done    <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          cnt <= '0;
          if (xfer) begin
            busy <= 1'b1;
            if (in_last) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              state    <= STREAM;
              in_ready <= 1'b1;
            end
          end else begin
            busy     <= (state == STREAM);
            in_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == LAST_CNT) begin
            state    <= IDLE;
            cnt      <= '0;
            done     <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
